multi_sel_sched: RTL and testbench
==================================

// Module: multi_sel_sched
// PURPOSE
//  Round-robin scheduler that shares one shift-add constant-multiplier datapath among N_REQ
//  requesters. A granted operand d produces four results over four consecutive cycles:
//  d*1, d*3, d*7, d*8. Each result carries its requester ID and a step index.
//  Sits between operand producers and the result consumer in the 58_sets arithmetic group.
// PARAMETERS
//  N_REQ  4          number of requesters (2..8)
//  DW     8          operand width
//  OW     DW+3       result width (d*8 max = 2040 for DW=8, fits 11 bits)
//  IDW    $clog2(N_REQ)  requester-ID width (derived localparam)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         reset: synchronous, active-high
//  req_valid  in   N_REQ     per-requester operand valid
//  req_data   in   N_REQ*DW  operands, requester i at [i*DW +: DW]
//  req_ready  out  N_REQ     one-hot grant, combinational from state + req_valid
//  out_valid  out  1         registered result valid
//  out_id     out  IDW       requester ID owning out_data
//  out_step   out  2         0:*1 1:*3 2:*7 3:*8
//  out_data   out  OW        registered product
//  busy       out  1         high while a sequence is running (RUN state)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, step=0, rr_ptr=0, out_valid=0, out_id=0,
//    out_step=0, out_data=0. Captured operand cleared. busy=0, req_ready=0.
//  FSM states: IDLE, RUN. step is a 2-bit counter used only in RUN.
//  Accept point: state==IDLE, or state==RUN with step==3.
//    At an accept point with any req_valid, req_ready is one-hot on the first valid requester
//    at or after rr_ptr, wrapping N_REQ-1 -> 0. With no req_valid, req_ready=0.
//  Handshake = req_valid[i] & req_ready[i] in cycle T.
//    On handshake: capture operand and ID, set rr_ptr = i+1 (mod N_REQ), step=0, enter RUN.
//  RUN: each cycle registers out_valid=1, out_step=step, out_id=captured ID.
//    out_data = operand*{1,3,7,8}[step], computed by shift-add only (d, (d<<1)+d,
//    (d<<3)-d, d<<3). All terms are zero-extended to OW before the add or subtract. No '*'.
//  Latency: handshake at cycle T -> out_valid high in cycles T+1..T+4 with steps 0,1,2,3.
//  Step 3 with no new handshake -> IDLE, out_valid=0 next cycle.
//  Step 3 with a handshake -> RUN step 0 for the new operand.
//    Back-to-back throughput: one operand per 4 cycles, out_valid never drops.
//  The requester must hold req_data stable while req_valid=1 and not granted.
//    Dropping req_valid before the grant is legal and has no effect.
//  Ungranted requesters are never starved. Max wait is (N_REQ-1) sequences.
//  rst asserted mid-sequence: the sequence is aborted and its remaining steps are never emitted.
//    All state returns to reset values on the next edge.
//  Operand 0 produces four zero results with out_valid=1. Max operand 255 gives 255/765/1785/2040.
// STRUCTURE
//  Shared package multi_sel_pkg:
//    state enum {IDLE,RUN}
//    step localparams STEP_X1..STEP_X8
//    coefficient table {1,3,7,8} used for scoreboard reference
//  Sub-module mul_const_unit: combinational DW->OW shift-add multiplier with step select.
//  This top keeps the arbiter, rr_ptr, FSM and output registers.
// TESTING
//  1. Reset, then req_valid=4'b0001, d0=8'd5 -> req_ready=0001; next 4 cycles out_data=5,15,35,40,
//     out_id=0, out_step 0..3; then out_valid=0.
//  2. All four requesters valid (d=1,2,3,4) held continuously -> grant order 0,1,2,3,0.
//     out_valid stays high for 16+ cycles, ID changes every 4 cycles.
//  3. rr_ptr=2 after granting req1; only req0 and req3 valid -> req3 granted first, then req0.
//  4. d=8'hFF -> 255, 765, 1785, 2040; no overflow in 11 bits.
//  5. rst=1 in step 1 of a sequence -> next cycle out_valid=0, busy=0, rr_ptr=0.
//     The following request is served from step 0.
//  6. req_valid[2] pulsed for one cycle while busy at step 1 -> never granted, no output for ID 2.

Source files
------------

// File: rtl/multi_sel_pkg.sv
// multi_sel_pkg: shared types and constants for the multi_sel_sched scheduler
package multi_sel_pkg;
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [1:0] STEP_X1 = 2'd0;
   localparam logic [1:0] STEP_X3 = 2'd1;
   localparam logic [1:0] STEP_X7 = 2'd2;
   localparam logic [1:0] STEP_X8 = 2'd3;
   localparam int unsigned COEF [4] = '{1, 3, 7, 8};
endpackage

// File: rtl/mul_const_unit.sv
// mul_const_unit: combinational shift-add multiply of an operand by 1/3/7/8 chosen by step
//   i_d    operand (DW bits)
//   i_step coefficient select: 0:*1 1:*3 2:*7 3:*8
//   o_prod product (OW bits)
module mul_const_unit
   import multi_sel_pkg::*;
#(
   parameter int DW = 8,
   parameter int OW = DW + 3
) (
   input  logic [DW-1:0] i_d,
   input  logic [1:0]    i_step,
   output logic [OW-1:0] o_prod
);
   logic [OW-1:0] w_d;
   assign w_d = OW'(i_d);
   assign o_prod = (i_step == STEP_X1) ? w_d :
                   (i_step == STEP_X3) ? (w_d << 1) + w_d :
                   (i_step == STEP_X7) ? (w_d << 3) - w_d :
                                         w_d << 3;
endmodule

// File: rtl/multi_sel_sched.sv
// multi_sel_sched: round-robin scheduler sharing one constant multiplier among N_REQ requesters
//   clk, rst   clock, synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_data   operands, requester i at [i*DW +: DW]
//   req_ready  one-hot grant (combinational)
//   out_valid  result valid
//   out_id     requester owning out_data
//   out_step   0:*1 1:*3 2:*7 3:*8
//   out_data   product
//   busy       sequence running
module multi_sel_sched
   import multi_sel_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = 8,
   parameter int OW    = DW + 3,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   output logic                out_valid,
   output logic [IDW-1:0]      out_id,
   output logic [1:0]          out_step,
   output logic [OW-1:0]       out_data,
   output logic                busy
);
   state_t         r_state, w_state_nxt;
   logic [1:0]     r_step, w_step;
   logic [IDW-1:0] r_ptr, r_id, w_gid, w_ptr_nxt;
   logic [DW-1:0]  r_d, w_sel_d;
   logic [OW-1:0]  r_data, w_prod;
   logic           r_valid, w_found, w_run, w_last, w_acc, w_hs, w_emit;
   // r_step is the step currently on the output, so the accept point coincides
   // with the step-3 result and back-to-back sequences leave no gap.
   assign w_run  = r_state == RUN;
   assign w_last = w_run && r_step == STEP_X8;
   assign w_acc  = !w_run || w_last;
   assign w_hs   = w_acc && w_found;
   assign w_emit = w_hs || (w_run && !w_last);
   always_comb begin
      w_found = 1'b0;
      w_gid   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = (int'(r_ptr) + k) % N_REQ;
         if (!w_found && req_valid[j]) begin
            w_found = 1'b1;
            w_gid   = IDW'(j);
         end
      end
   end
   assign req_ready   = w_hs ? N_REQ'(1'b1) << w_gid : '0;
   assign w_ptr_nxt   = (w_gid == IDW'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
   assign w_sel_d     = w_hs ? req_data[w_gid*DW +: DW] : r_d;
   assign w_step      = w_hs ? STEP_X1 : r_step + 2'd1;
   assign w_state_nxt = w_hs ? RUN : w_last ? IDLE : r_state;
   mul_const_unit #(.DW(DW), .OW(OW)) u_mul (
      .i_d    (w_sel_d),
      .i_step (w_step),
      .o_prod (w_prod)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_ptr   <= '0;
         r_id    <= '0;
         r_d     <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_emit;
         if (w_emit) begin
            r_step <= w_step;
            r_data <= w_prod;
         end
         if (w_hs) begin
            r_d   <= w_sel_d;
            r_id  <= w_gid;
            r_ptr <= w_ptr_nxt;
         end
      end
   end
   assign out_valid = r_valid;
   assign out_id    = r_id;
   assign out_step  = r_step;
   assign out_data  = r_data;
   assign busy      = w_run;
endmodule

// File: tb/tb_multi_sel_sched.sv
// tb_multi_sel_sched: directed self-checking bench for multi_sel_sched
module tb_multi_sel_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [1:0]  out_id;
   logic [1:0]  out_step;
   logic [10:0] out_data;
   logic        busy;
   int n_chk = 0;
   int n_err = 0;
   multi_sel_sched #(.N_REQ(4), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_step  (out_step),
      .out_data  (out_data),
      .busy      (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic set_d(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask
   task automatic expect_seq(input string tag, input int id, input int p0, input int p1,
                             input int p2, input int p3, input logic [3:0] rdy3);
      int p [4];
      p = '{p0, p1, p2, p3};
      for (int k = 0; k < 4; k++) begin
         #1;
         chk({tag, "_valid"}, 32'(out_valid), 1);
         chk({tag, "_busy"}, 32'(busy), 1);
         chk({tag, "_id"}, 32'(out_id), 32'(id));
         chk({tag, "_step"}, 32'(out_step), 32'(k));
         chk({tag, "_data"}, 32'(out_data), 32'(p[k]));
         if (k == 3) chk({tag, "_rdy3"}, 32'(req_ready), 32'(rdy3));
         step();
      end
   endtask
   initial begin
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_id", 32'(out_id), 0);
      chk("rst_step", 32'(out_step), 0);
      chk("rst_rdy", 32'(req_ready), 0);
      set_d(0, 8'd5);
      req_valid = 4'b0001;
      #1;
      chk("t1_rdy", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      expect_seq("t1", 0, 5, 15, 35, 40, 4'b0000);
      #1;
      chk("t1_end_valid", 32'(out_valid), 0);
      chk("t1_end_busy", 32'(busy), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_d(0, 8'd1);
      set_d(1, 8'd2);
      set_d(2, 8'd3);
      set_d(3, 8'd4);
      req_valid = 4'b1111;
      #1;
      chk("t2_rdy", 32'(req_ready), 32'b0001);
      step();
      expect_seq("t2_g0", 0, 1, 3, 7, 8, 4'b0010);
      expect_seq("t2_g1", 1, 2, 6, 14, 16, 4'b0100);
      expect_seq("t2_g2", 2, 3, 9, 21, 24, 4'b1000);
      expect_seq("t2_g3", 3, 4, 12, 28, 32, 4'b0001);
      expect_seq("t2_g0b", 0, 1, 3, 7, 8, 4'b0010);
      req_valid = '0;
      expect_seq("t2_g1b", 1, 2, 6, 14, 16, 4'b0000);
      #1;
      chk("t2_end_valid", 32'(out_valid), 0);
      set_d(0, 8'd9);
      set_d(3, 8'd10);
      req_valid = 4'b1001;
      #1;
      chk("t3_rdy", 32'(req_ready), 32'b1000);
      step();
      req_valid = 4'b0001;
      expect_seq("t3_g3", 3, 10, 30, 70, 80, 4'b0001);
      req_valid = '0;
      expect_seq("t3_g0", 0, 9, 27, 63, 72, 4'b0000);
      set_d(2, 8'hFF);
      req_valid = 4'b0100;
      #1;
      chk("t4_rdy", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      expect_seq("t4", 2, 255, 765, 1785, 2040, 4'b0000);
      set_d(1, 8'd7);
      req_valid = 4'b0010;
      #1;
      chk("t5_rdy", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      step();
      #1;
      chk("t5_s1_step", 32'(out_step), 1);
      chk("t5_s1_data", 32'(out_data), 21);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      step();
      #1;
      chk("t5_idle_valid", 32'(out_valid), 0);
      set_d(0, 8'd5);
      req_valid = 4'b0011;
      #1;
      chk("t5_ptr0_rdy", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      expect_seq("t5", 0, 5, 15, 35, 40, 4'b0000);
      req_valid = 4'b0001;
      #1;
      chk("t6_rdy", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      step();
      set_d(2, 8'd3);
      req_valid = 4'b0100;
      #1;
      chk("t6_pulse_rdy", 32'(req_ready), 0);
      chk("t6_s1_data", 32'(out_data), 15);
      step();
      req_valid = '0;
      #1;
      chk("t6_s2_id", 32'(out_id), 0);
      chk("t6_s2_data", 32'(out_data), 35);
      step();
      #1;
      chk("t6_s3_id", 32'(out_id), 0);
      chk("t6_s3_data", 32'(out_data), 40);
      chk("t6_s3_rdy", 32'(req_ready), 0);
      step();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t6_idle_valid", 32'(out_valid), 0);
         chk("t6_idle_busy", 32'(busy), 0);
         step();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
